// File: rtl/mic_apb_pkg.sv
// rtl/mic_apb_pkg.sv - shared types and APB widths for the microphone sample sequencer
package mic_apb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } seq_state_t;

  localparam int ADDR_W   = 12;
  localparam int PRDATA_W = 16;
  localparam int PWDATA_W = 32;
  localparam int SAMPLE_W = 12;

  localparam logic [ADDR_W-1:0] DEFAULT_SAMPLE_ADDR = 12'h000;
endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - small power-of-two sample FIFO; push on full only succeeds with a same-cycle pop
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/mic_sample_sequencer.sv
// rtl/mic_sample_sequencer.sv - APB read master merging periodic and quick-sample requests into a sample FIFO
module mic_sample_sequencer
  import mic_apb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SAMPLE_ADDR = DEFAULT_SAMPLE_ADDR,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                enable,
  input  logic [15:0]         period,
  input  logic                quick_sample,
  input  logic                clr_status,
  output logic                PSEL,
  output logic                PENABLE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PWRITE,
  output logic [PWDATA_W-1:0] PWDATA,
  input  logic [PRDATA_W-1:0] PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overflow,
  output logic                req_overrun,
  output logic [7:0]          err_count,
  output logic [7:0]          timeout_count
);
  localparam int WAIT_W = $clog2(TIMEOUT);

  seq_state_t        r_state;
  logic              r_psel;
  logic              r_penable;
  logic [WAIT_W-1:0] r_wait;
  logic              r_qs_h;
  logic              r_pending;
  logic [15:0]       r_tmr;
  logic              r_overflow;
  logic              r_req_overrun;
  logic [7:0]        r_err_count;
  logic [7:0]        r_timeout_count;

  logic w_qs_edge, w_timer_on, w_tick, w_event, w_start;
  logic w_complete, w_timeout, w_push, w_pop, w_drop;
  logic w_full, w_empty;
  logic w_unused;

  assign w_qs_edge  = quick_sample & ~r_qs_h;
  assign w_timer_on = enable && (period != 16'd0);
  assign w_tick     = w_timer_on && (r_tmr == period - 16'd1);
  assign w_event    = w_tick | w_qs_edge;
  assign w_start    = (r_state == IDLE) && (r_pending || w_event);
  assign w_complete = (r_state == ACCESS) && PREADY;
  assign w_timeout  = (r_state == ACCESS) && !PREADY && (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_push     = w_complete && !PSLVERR;
  assign w_pop      = ~w_empty & sample_ready;
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_unused   = ^PRDATA[PRDATA_W-1:SAMPLE_W];

  assign PSEL          = r_psel;
  assign PENABLE       = r_penable;
  assign PADDR         = SAMPLE_ADDR;
  assign PWRITE        = 1'b0;
  assign PWDATA        = '0;
  assign sample_valid  = ~w_empty;
  assign overflow      = r_overflow;
  assign req_overrun   = r_req_overrun;
  assign err_count     = r_err_count;
  assign timeout_count = r_timeout_count;

  // A shortened period that leaves tmr beyond the new compare wraps silently.
  always_ff @(posedge sysclk) begin
    if (reset || !w_timer_on || r_tmr >= period || w_tick) r_tmr <= '0;
    else                                                   r_tmr <= r_tmr + 16'd1;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_qs_h    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_qs_h <= quick_sample;
      if (w_start)      r_pending <= 1'b0;
      else if (w_event) r_pending <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_wait    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= SETUP;
          r_psel  <= 1'b1;
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          r_wait    <= '0;
        end
        ACCESS: if (w_complete || w_timeout) begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset || clr_status) begin
      r_overflow      <= 1'b0;
      r_req_overrun   <= 1'b0;
      r_err_count     <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_event && (r_pending || r_state != IDLE)) r_req_overrun <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_complete && PSLVERR && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      if (w_timeout && r_timeout_count != 8'hFF) r_timeout_count <= r_timeout_count + 8'd1;
    end
  end

  sample_fifo #(
    .WIDTH(SAMPLE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (sysclk),
    .i_reset(reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (PRDATA[SAMPLE_W-1:0]),
    .o_data (sample_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_mic_sample_sequencer.sv
// tb/tb_mic_sample_sequencer.sv - self-checking bench for mic_sample_sequencer
module tb_mic_sample_sequencer;
  logic        sysclk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, quick_sample = 1'b0, clr_status = 1'b0;
  logic [15:0] period = 16'd0, PRDATA = 16'd0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0, sample_ready = 1'b0;
  logic        PSEL, PENABLE, PWRITE, sample_valid, overflow, req_overrun;
  logic [11:0] PADDR, sample_data;
  logic [31:0] PWDATA;
  logic [7:0]  err_count, timeout_count;

  int checks = 0;
  int errors = 0;
  logic [11:0] model_q[$];

  always #5 sysclk = ~sysclk;

  mic_sample_sequencer dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .period(period),
    .quick_sample(quick_sample), .clr_status(clr_status),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overflow(overflow), .req_overrun(req_overrun),
    .err_count(err_count), .timeout_count(timeout_count)
  );

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge sysclk);
    clr_status = 1'b0;
  endtask

  // One quick_sample-initiated transfer; slave holds PREADY low for 'waits' ACCESS cycles.
  task automatic xfer(input int waits, input logic err, input logic [15:0] data,
                      output int acc, output logic addr_ok);
    int n;
    addr_ok = 1'b1;
    quick_sample = 1'b1;
    @(negedge sysclk);
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin
      errors++; $display("FAIL setup_phase: PSEL=%b PENABLE=%b, required 1/0", PSEL, PENABLE);
    end
    quick_sample = 1'b0;
    @(negedge sysclk);
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      errors++; $display("FAIL access_phase: PSEL=%b PENABLE=%b, required 1/1", PSEL, PENABLE);
    end
    n = 0;
    while (PENABLE === 1'b1 && n < 300) begin
      if (PADDR !== 12'h000 || PSEL !== 1'b1 || PWRITE !== 1'b0) addr_ok = 1'b0;
      PREADY = (n >= waits); PRDATA = data; PSLVERR = err;
      @(negedge sysclk);
      n++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    acc = n;
  endtask

  task automatic drain_check();
    int guard = 0;
    while (model_q.size() > 0 && guard < 20) begin
      checks++;
      if (sample_valid !== 1'b1 || sample_data !== model_q[0]) begin
        errors++;
        $display("FAIL drain_data: valid=%b data=%h, required 1/%h", sample_valid, sample_data, model_q[0]);
      end
      void'(model_q.pop_front());
      sample_ready = 1'b1;
      @(negedge sysclk);
      sample_ready = 1'b0;
      guard++;
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: sample_valid=%b, required 0", sample_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    checks++;
    if ({PSEL, PENABLE, sample_valid, overflow, req_overrun, err_count, timeout_count} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: psel=%b pen=%b valid=%b ovf=%b ovr=%b err=%0d to=%0d, required all 0",
               PSEL, PENABLE, sample_valid, overflow, req_overrun, err_count, timeout_count);
    end
    checks++;
    if (PADDR !== 12'h000 || PWRITE !== 1'b0 || PWDATA !== 32'd0) begin
      errors++; $display("FAIL reset_consts: PADDR=%h PWRITE=%b PWDATA=%h, required 000/0/0", PADDR, PWRITE, PWDATA);
    end
  endtask

  task automatic test_single();
    int acc; logic aok;
    xfer(0, 1'b0, 16'hFABC, acc, aok);
    checks++;
    if (acc != 1) begin errors++; $display("FAIL single_access_len: %0d, required 1", acc); end
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 12'hABC) begin
      errors++; $display("FAIL single_sample: valid=%b data=%h, required 1/abc", sample_valid, sample_data);
    end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL single_err: %0d, required 0", err_count); end
    model_q.push_back(12'hABC);
    drain_check();
  endtask

  task automatic test_wait_err();
    int acc; logic aok;
    xfer(5, 1'b1, 16'($urandom), acc, aok);
    checks++;
    if (acc != 6) begin errors++; $display("FAIL wait_access_len: %0d, required 6", acc); end
    checks++;
    if (aok !== 1'b1) begin errors++; $display("FAIL wait_addr_stable: %b, required 1", aok); end
    checks++;
    if (sample_valid !== 1'b0 || err_count !== 8'd1) begin
      errors++; $display("FAIL wait_slverr: valid=%b err=%0d, required 0/1", sample_valid, err_count);
    end
  endtask

  task automatic test_timeout();
    int acc; logic aok; logic [15:0] d;
    xfer(1000, 1'b0, 16'($urandom), acc, aok);
    checks++;
    if (acc != 64) begin errors++; $display("FAIL timeout_len: %0d, required 64", acc); end
    checks++;
    if (PSEL !== 1'b0 || timeout_count !== 8'd1 || sample_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_state: psel=%b to=%0d valid=%b, required 0/1/0", PSEL, timeout_count, sample_valid);
    end
    d = 16'($urandom);
    xfer(0, 1'b0, d, acc, aok);
    checks++;
    if (acc != 1) begin errors++; $display("FAIL after_timeout_len: %0d, required 1", acc); end
    model_q.push_back(d[11:0]);
    drain_check();
  endtask

  task automatic test_overflow();
    int comps = 0; int guard = 0; logic exp_ovf = 1'b0;
    period = 16'd10; PSLVERR = 1'b0; PREADY = 1'b1; sample_ready = 1'b0; enable = 1'b1;
    while (comps < 5 && guard < 200) begin
      if (PENABLE === 1'b1) begin
        PRDATA = 16'($urandom);
        comps++;
        if (model_q.size() < 4) model_q.push_back(PRDATA[11:0]);
        else exp_ovf = 1'b1;
      end
      @(negedge sysclk);
      guard++;
      checks++;
      if (overflow !== exp_ovf) begin
        errors++; $display("FAIL overflow_flag: %b after %0d completions, required %b", overflow, comps, exp_ovf);
      end
    end
    checks++;
    if (comps != 5) begin errors++; $display("FAIL overflow_completions: %0d, required 5", comps); end
    pulse_clr();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr: %b, required 0", overflow); end
    guard = 0;
    while (PENABLE !== 1'b1 && guard < 40) begin @(negedge sysclk); guard++; end
    checks++;
    if (PENABLE !== 1'b1) begin errors++; $display("FAIL overflow_6th_wait: PENABLE=%b, required 1", PENABLE); end
    PRDATA = 16'($urandom);
    sample_ready = 1'b1;
    enable = 1'b0;
    checks++;
    if (sample_data !== model_q[0]) begin
      errors++; $display("FAIL overflow_head: %h, required %h", sample_data, model_q[0]);
    end
    void'(model_q.pop_front());
    model_q.push_back(PRDATA[11:0]);
    @(negedge sysclk);
    sample_ready = 1'b0;
    PREADY = 1'b0;
    checks++;
    if (overflow !== 1'b0 || req_overrun !== 1'b0) begin
      errors++; $display("FAIL overflow_poppush: ovf=%b ovr=%b, required 0/0", overflow, req_overrun);
    end
    drain_check();
  endtask

  task automatic test_coalesce();
    int starts = 0; logic prev = 1'b0;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 16'($urandom);
    period = 16'd5; enable = 1'b1;
    repeat (4) @(negedge sysclk);
    quick_sample = 1'b1;
    @(negedge sysclk);
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (PSEL === 1'b1 && !prev) starts++;
      prev = PSEL;
      quick_sample = 1'b0;
      @(negedge sysclk);
    end
    checks++;
    if (starts != 1 || req_overrun !== 1'b0) begin
      errors++; $display("FAIL coalesce_same_cycle: transfers=%0d ovr=%b, required 1/0", starts, req_overrun);
    end
    model_q.push_back(PRDATA[11:0]);
    drain_check();
    starts = 0; prev = 1'b0;
    period = 16'd1; enable = 1'b1; quick_sample = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sysclk);
      if (PSEL === 1'b1 && !prev) starts++;
      prev = PSEL;
    end
    enable = 1'b0; quick_sample = 1'b0;
    checks++;
    if (starts != 10 || req_overrun !== 1'b1) begin
      errors++; $display("FAIL coalesce_period1: transfers=%0d ovr=%b, required 10/1", starts, req_overrun);
    end
    repeat (8) @(negedge sysclk);
    PREADY = 1'b0;
    pulse_clr();
    sample_ready = 1'b1;
    repeat (6) @(negedge sysclk);
    sample_ready = 1'b0;
    checks++;
    if (sample_valid !== 1'b0 || req_overrun !== 1'b0) begin
      errors++; $display("FAIL coalesce_cleanup: valid=%b ovr=%b, required 0/0", sample_valid, req_overrun);
    end
  endtask

  task automatic test_reset_mid();
    int acc; logic aok; logic stray = 1'b0;
    xfer(0, 1'b1, 16'($urandom), acc, aok);
    xfer(0, 1'b0, 16'($urandom), acc, aok);
    quick_sample = 1'b1;
    @(negedge sysclk);
    quick_sample = 1'b0;
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    checks++;
    if ({PSEL, PENABLE, sample_valid} !== 3'b000 || err_count !== 8'd0 || timeout_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_state: psel=%b pen=%b valid=%b err=%0d to=%0d, required 0/0/0/0/0",
               PSEL, PENABLE, sample_valid, err_count, timeout_count);
    end
    PREADY = 1'b1; PRDATA = 16'($urandom);
    repeat (5) begin
      @(negedge sysclk);
      if (PSEL !== 1'b0 || sample_valid !== 1'b0) stray = 1'b1;
    end
    PREADY = 1'b0;
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL reset_mid_nopush: stray=%b, required 0", stray); end
  endtask

  task automatic test_random();
    int acc; logic aok; int w; logic e; logic [15:0] d; int k; int exp_err; logic exp_ovf;
    for (int r = 0; r < 4; r++) begin
      pulse_clr();
      exp_err = 0; exp_ovf = 1'b0;
      k = $urandom_range(1, 6);
      for (int t = 0; t < k; t++) begin
        w = $urandom_range(0, 3);
        e = ($urandom_range(0, 3) == 0);
        d = 16'($urandom);
        xfer(w, e, d, acc, aok);
        checks++;
        if (acc != w + 1 || aok !== 1'b1) begin
          errors++; $display("FAIL random_access: len=%0d addr_ok=%b, required %0d/1", acc, aok, w + 1);
        end
        if (e) exp_err++;
        else if (model_q.size() < 4) model_q.push_back(d[11:0]);
        else exp_ovf = 1'b1;
      end
      checks++;
      if (err_count !== 8'(exp_err) || overflow !== exp_ovf || timeout_count !== 8'd0) begin
        errors++;
        $display("FAIL random_status: err=%0d ovf=%b to=%0d, required %0d/%b/0", err_count, overflow,
                 timeout_count, exp_err, exp_ovf);
      end
      drain_check();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge sysclk);
    test_reset();
    test_single();
    test_wait_err();
    test_timeout();
    test_overflow();
    test_coalesce();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
